// File: rtl/wb_scoreboard.sv
// In-order writeback scoreboard: expected commits queue in a FIFO and are checked
// against the core's writeback stream, with a drain/timeout FSM and pass/fail verdict.
module wb_scoreboard #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             end_of_test,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic             exp_we,
  input  logic [RA_W-1:0]  exp_rd,
  input  logic [XLEN-1:0]  exp_data,
  input  logic             wb_valid,
  input  logic             wb_we,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] error_count,
  output logic             mismatch,
  output logic [RA_W-1:0]  first_err_rd,
  output logic [XLEN-1:0]  first_err_exp,
  output logic [XLEN-1:0]  first_err_got,
  output logic             timeout,
  output logic             done,
  output logic             test_pass
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [TW-1:0]    r_tcnt;
  logic             r_mem_we   [DEPTH];
  logic [RA_W-1:0]  r_mem_rd   [DEPTH];
  logic [XLEN-1:0]  r_mem_data [DEPTH];

  logic [CNT_W-1:0] r_pass, r_err;
  logic             r_mismatch, r_timeout;
  logic [RA_W-1:0]  r_ferr_rd;
  logic [XLEN-1:0]  r_ferr_exp, r_ferr_got;

  logic w_active, w_empty, w_push, w_check, w_pop, w_unexp;
  logic w_exp_nw, w_wb_nw, w_match, w_pass, w_err, w_restart, w_stall, w_tmo_hit;
  logic            w_head_we;
  logic [RA_W-1:0] w_head_rd;
  logic [XLEN-1:0] w_head_data;

  assign w_active  = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_empty   = (r_count == {CW{1'b0}});
  assign exp_ready = (r_state == S_RUN) && (r_count < CW'(DEPTH));
  assign w_push    = exp_valid && exp_ready;
  assign w_check   = w_active && wb_valid;
  assign w_pop     = w_check && !w_empty;
  assign w_unexp   = w_check && w_empty;
  assign w_restart = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_head_we   = r_mem_we[r_rptr];
  assign w_head_rd   = r_mem_rd[r_rptr];
  assign w_head_data = r_mem_data[r_rptr];

  // Writes to x0 or with we==0 are architecturally invisible, so both count as "no write"
  assign w_exp_nw = !w_head_we || (w_head_rd == {RA_W{1'b0}});
  assign w_wb_nw  = !wb_we || (wb_rd == {RA_W{1'b0}});
  assign w_match  = (w_exp_nw && w_wb_nw) ||
                    (!w_exp_nw && !w_wb_nw && (w_head_rd == wb_rd) && (w_head_data == wb_data));
  assign w_pass   = w_pop && w_match;
  assign w_err    = w_unexp || (w_pop && !w_match);

  assign w_stall   = w_active && !w_empty && !wb_valid;
  assign w_tmo_hit = w_stall && (r_tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN; else w_next = S_IDLE;
      S_RUN:   if (w_tmo_hit) w_next = S_DONE;
               else if (end_of_test) w_next = S_DRAIN;
               else w_next = S_RUN;
      S_DRAIN: if (w_tmo_hit || w_empty) w_next = S_DONE; else w_next = S_DRAIN;
      S_DONE:  if (start) w_next = S_RUN; else w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (w_restart) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_we[r_wptr]   <= exp_we;
      r_mem_rd[r_wptr]   <= exp_rd;
      r_mem_data[r_wptr] <= exp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt    <= {TW{1'b0}};
      r_timeout <= 1'b0;
    end else if (w_restart) begin
      r_tcnt    <= {TW{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      if (w_stall) r_tcnt <= r_tcnt + TW'(1);
      else         r_tcnt <= {TW{1'b0}};
      if (w_tmo_hit) r_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass     <= {CNT_W{1'b0}};
      r_err      <= {CNT_W{1'b0}};
      r_mismatch <= 1'b0;
      r_ferr_rd  <= {RA_W{1'b0}};
      r_ferr_exp <= {XLEN{1'b0}};
      r_ferr_got <= {XLEN{1'b0}};
    end else if (w_restart) begin
      r_pass     <= {CNT_W{1'b0}};
      r_err      <= {CNT_W{1'b0}};
      r_mismatch <= 1'b0;
      r_ferr_rd  <= {RA_W{1'b0}};
      r_ferr_exp <= {XLEN{1'b0}};
      r_ferr_got <= {XLEN{1'b0}};
    end else begin
      r_mismatch <= w_err;
      if (w_pass && (r_pass != {CNT_W{1'b1}})) r_pass <= r_pass + CNT_W'(1);
      if (w_err && (r_err != {CNT_W{1'b1}}))   r_err  <= r_err + CNT_W'(1);
      if (w_err && (r_err == {CNT_W{1'b0}})) begin
        r_ferr_rd  <= wb_rd;
        r_ferr_exp <= w_unexp ? {XLEN{1'b0}} : w_head_data;
        r_ferr_got <= wb_data;
      end
    end
  end

  assign pass_count    = r_pass;
  assign error_count   = r_err;
  assign mismatch      = r_mismatch;
  assign first_err_rd  = r_ferr_rd;
  assign first_err_exp = r_ferr_exp;
  assign first_err_got = r_ferr_got;
  assign timeout       = r_timeout;
  assign done          = (r_state == S_DONE);
  assign test_pass     = done && (r_err == {CNT_W{1'b0}}) && !r_timeout;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: matching run, mismatches, unexpected commits,
// full FIFO, timeout and asynchronous reset mid-drain.
module tb_wb_scoreboard;
  localparam int XLEN = 32, RA_W = 5, DEPTH = 8, TIMEOUT = 64, CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0, end_of_test = 1'b0;
  logic             exp_valid = 1'b0, exp_we = 1'b0;
  logic [RA_W-1:0]  exp_rd = '0;
  logic [XLEN-1:0]  exp_data = '0;
  logic             wb_valid = 1'b0, wb_we = 1'b0;
  logic [RA_W-1:0]  wb_rd = '0;
  logic [XLEN-1:0]  wb_data = '0;
  logic             exp_ready, mismatch, timeout, done, test_pass;
  logic [CNT_W-1:0] pass_count, error_count;
  logic [RA_W-1:0]  first_err_rd;
  logic [XLEN-1:0]  first_err_exp, first_err_got;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  wb_scoreboard #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .end_of_test(end_of_test),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_we(exp_we), .exp_rd(exp_rd), .exp_data(exp_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .pass_count(pass_count), .error_count(error_count), .mismatch(mismatch),
    .first_err_rd(first_err_rd), .first_err_exp(first_err_exp), .first_err_got(first_err_got),
    .timeout(timeout), .done(done), .test_pass(test_pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [RA_W-1:0] rd, input logic [XLEN-1:0] d);
    exp_valid = 1'b1; exp_we = we; exp_rd = rd; exp_data = d;
    tick;
    exp_valid = 1'b0;
  endtask

  task automatic commit(input logic we, input logic [RA_W-1:0] rd, input logic [XLEN-1:0] d);
    wb_valid = 1'b1; wb_we = we; wb_rd = rd; wb_data = d;
    tick;
    wb_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic pulse_eot;
    end_of_test = 1'b1; tick; end_of_test = 1'b0;
  endtask

  initial begin
    repeat (2) tick;
    check("rst_pass", pass_count, 0);
    check("rst_err", error_count, 0);
    check("rst_ready", exp_ready, 0);
    check("rst_done", done, 0);
    check("rst_tpass", test_pass, 0);
    rst = 1'b0;
    tick;

    // Clean run: two real writes plus a no-write entry
    pulse_start;
    check("t1_ready", exp_ready, 1);
    push(1'b1, 5'd1, 32'h8);
    push(1'b1, 5'd1, 32'h11);
    push(1'b0, 5'd0, 32'h0);
    commit(1'b1, 5'd1, 32'h8);
    commit(1'b1, 5'd1, 32'h11);
    commit(1'b0, 5'd3, 32'h55);
    check("t1_pass", pass_count, 3);
    check("t1_err", error_count, 0);
    pulse_eot;
    check("t1_drain_done", done, 0);
    tick;
    check("t1_done", done, 1);
    check("t1_tpass", test_pass, 1);

    // Data mismatch, then a second error leaves first_err_* untouched
    pulse_start;
    check("t2_clr_pass", pass_count, 0);
    check("t2_clr_done", done, 0);
    push(1'b1, 5'd5, 32'hA);
    commit(1'b1, 5'd5, 32'hB);
    check("t2_mm", mismatch, 1);
    check("t2_err", error_count, 1);
    check("t2_frd", first_err_rd, 5);
    check("t2_fexp", first_err_exp, 32'hA);
    check("t2_fgot", first_err_got, 32'hB);
    tick;
    check("t2_mm_pulse", mismatch, 0);
    push(1'b1, 5'd6, 32'hC);
    commit(1'b1, 5'd6, 32'hD);
    check("t2_err2", error_count, 2);
    check("t2_frd_hold", first_err_rd, 5);
    check("t2_fgot_hold", first_err_got, 32'hB);
    pulse_eot;
    tick;
    check("t2_done", done, 1);
    check("t2_tpass", test_pass, 0);

    // Unexpected commit with a same-cycle push: no empty bypass
    pulse_start;
    exp_valid = 1'b1; exp_we = 1'b1; exp_rd = 5'd7; exp_data = 32'h77;
    wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
    tick;
    exp_valid = 1'b0; wb_valid = 1'b0;
    check("t3_err", error_count, 1);
    check("t3_fexp", first_err_exp, 0);
    check("t3_fgot", first_err_got, 32'h77);
    check("t3_frd", first_err_rd, 7);
    commit(1'b1, 5'd7, 32'h77);
    check("t3_kept", pass_count, 1);
    commit(1'b1, 5'd7, 32'h77);
    check("t3_one_entry", error_count, 2);
    pulse_eot;
    tick;
    check("t3_done", done, 1);

    // Full FIFO: push refused even with a same-cycle pop; x0 writes always match
    pulse_start;
    for (int i = 0; i < DEPTH; i++) push(1'b1, 5'd0, 32'(i));
    check("t4_full_ready", exp_ready, 0);
    exp_valid = 1'b1; exp_we = 1'b1; exp_rd = 5'd2; exp_data = 32'h99;
    wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    tick;
    exp_valid = 1'b0; wb_valid = 1'b0;
    check("t4_x0_pass", pass_count, 1);
    check("t4_ready7", exp_ready, 1);
    for (int i = 0; i < DEPTH - 1; i++) commit(1'b1, 5'd0, 32'(i * 3 + 100));
    check("t4_pass8", pass_count, 8);
    check("t4_err0", error_count, 0);
    commit(1'b1, 5'd2, 32'h99);
    check("t4_refused", error_count, 1);
    pulse_eot;
    tick;
    check("t4_done", done, 1);

    // Hang detection
    pulse_start;
    push(1'b1, 5'd3, 32'h1);
    push(1'b1, 5'd4, 32'h2);
    pulse_eot;
    n = 0;
    while (!done && n < 100) begin
      tick;
      n++;
    end
    check("t5_done", done, 1);
    check("t5_window", (n >= 58 && n <= 66), 1);
    check("t5_tmo", timeout, 1);
    check("t5_tpass", test_pass, 0);
    check("t5_err", error_count, 0);
    pulse_start;
    check("t5_tmo_clr", timeout, 0);
    check("t5_done_clr", done, 0);
    check("t5_run", exp_ready, 1);

    // Asynchronous reset in the middle of a drain
    commit(1'b1, 5'd9, 32'h5A);
    check("t6_err_pre", error_count, 1);
    for (int i = 0; i < 4; i++) push(1'b1, 5'(i + 1), 32'(i + 16));
    pulse_eot;
    check("t6_drain_ready", exp_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_arst_err", error_count, 0);
    check("t6_arst_fgot", first_err_got, 0);
    check("t6_arst_frd", first_err_rd, 0);
    rst = 1'b0;
    tick;
    tick;
    check("t6_idle_ready", exp_ready, 0);
    check("t6_idle_done", done, 0);
    pulse_start;
    check("t6_ready", exp_ready, 1);
    commit(1'b1, 5'd1, 32'h10);
    check("t6_fifo_clr", error_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Synthesizable, self-checking writeback scoreboard for the RISC-V pipeline bench.
- Expected commits (rd, data, write-enable) are queued in order by the stimulus side and compared against the core's writeback stream.
- Counts passes and errors, detects unexpected commits and hangs, and raises a final pass/fail verdict.
- Generalises the fixed-vector, fixed-delay checking to a parametrised in-order queue with a drain/timeout FSM.

Parameters:
- XLEN, 32, data width of register values.
- RA_W, 5, register address width.
- DEPTH, 8, expected-entry FIFO depth (power of two, >=2).
- TIMEOUT, 64, max cycles with a non-empty FIFO and no commit before a hang is declared.
- CNT_W, 16, pass/error counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin/restart a run (IDLE or DONE only).
- end_of_test  in  1  no more expected entries; begin drain.
- exp_valid  in  1  expected entry offered.
- exp_ready  out  1  entry accepted when exp_valid&&exp_ready.
- exp_we  in  1  expected register-write flag.
- exp_rd  in  RA_W  expected destination.
- exp_data  in  XLEN  expected write data.
- wb_valid  in  1  core commits an instruction this cycle.
- wb_we  in  1  core register-write enable.
- wb_rd  in  RA_W  core destination.
- wb_data  in  XLEN  core write data.
- pass_count  out  CNT_W  matching commits.
- error_count  out  CNT_W  mismatches plus unexpected commits.
- mismatch  out  1  one-cycle pulse on any error.
- first_err_rd  out  RA_W  rd of first error (sticky).
- first_err_exp  out  XLEN  expected data of first error.
- first_err_got  out  XLEN  observed data of first error.
- timeout  out  1  sticky hang flag.
- done  out  1  run finished.
- test_pass  out  1  done && error_count==0 && !timeout.

Behaviour:
- Reset (async, any time incl. mid-run): FSM=IDLE, FIFO empty, all outputs 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN.
  - RUN: end_of_test -> DRAIN. Timeout -> DONE.
  - DRAIN: FIFO empty at the clock edge -> DONE. Timeout -> DONE.
  - DONE: done=1, holds. start -> RUN, clearing FIFO, counters, first_err_* and timeout in the same edge.
- Enqueue:
  - exp_ready = (state==RUN) && count<DEPTH, from registered count.
  - No full-bypass: a push while full is refused even if a pop occurs that cycle.
  - end_of_test and exp_valid in the same RUN cycle: the entry is accepted, then the FSM moves to DRAIN.
- Commit checking is active in RUN and DRAIN only; wb_valid is ignored in IDLE and DONE.
  - FIFO empty at wb_valid: unexpected commit, error. No empty-bypass: a same-cycle push is not compared.
  - Otherwise pop the head and compare, after normalising each side to "no write" when we==0 or rd==0. The commit matches iff:
    - both sides are "no write"; or
    - both sides write with equal rd and equal data.
  - A match increments pass_count; anything else is an error.
- Error effects, registered one cycle after the wb_valid edge:
  - error_count increments and mismatch pulses for exactly 1 cycle.
  - first_err_* are captured only when error_count was 0.
  - For an unexpected commit, first_err_exp = 0.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- FIFO pointers wrap modulo DEPTH. count is CLOG2(DEPTH)+1 bits. Simultaneous push+pop when neither full nor empty leaves count unchanged.
- Timeout counter:
  - Increments each RUN/DRAIN cycle with FIFO non-empty and no wb_valid.
  - Clears on wb_valid or when the FIFO is empty.
  - Reaching TIMEOUT sets timeout and moves to DONE next edge.
  - Entries remaining at that point are not counted as errors.
- test_pass is combinational from registered state.

Test Plan:
- Reset then start. Push 3 entries {we=1,rd=1,0x8}, {we=1,rd=1,0x11}, {we=0}. Matching commits 2 cycles later. end_of_test -> pass_count=3, error_count=0, done=1 within 1 cycle of drain, test_pass=1.
- Push {rd=5,0xA}. Commit {rd=5,0xB} -> mismatch pulse 1 cycle, error_count=1, first_err_rd=5, exp=0xA, got=0xB. A second wrong commit leaves first_err_* unchanged.
- wb_valid with FIFO empty (incl. same-cycle push) -> error_count=1, first_err_exp=0. The pushed entry remains, count=1.
- Fill DEPTH=8 entries: exp_ready=0. Push+commit in the same cycle -> push refused, count=7. Writes to x0 with differing data compare as match.
- Push 2 entries, end_of_test, no commits -> timeout=1 and done=1 after 64 cycles, test_pass=0. Then start -> counters cleared, state RUN.
- Assert rst mid-DRAIN with 4 entries queued -> all outputs 0 immediately (async), exp_ready=0 until start.
